id_ex_stage: RTL

ID/EX pipeline register with an integrated read-after-write interlock for the non-forwarding 5-stage RV32I pipeline. It consumes the ID-stage control bundle, operands and instruction, and registers them into EX. It tracks the destination registers of the instructions in EX, MEM and WB. When the ID instruction reads a register that an in-flight instruction has not yet written back, it stalls IF/ID and injects bubbles into EX.

---
 rtl/pipe_pkg.sv | 64 ++++++
 rtl/id_hazard_cmp.sv | 39 +++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control bundle, opcode constants, the EX
// bubble bundle and the source-usage helpers used by the RAW interlock.
package pipe_pkg;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_S     = 5'b01000;
  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_B     = 5'b11000;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_JAL   = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;

  typedef struct packed {
    logic       lui_sel;
    logic       rd_wren;
    logic       insn_vld;
    logic       br_un;
    logic       opa_sel;
    logic       opb_sel;
    logic       mem_wren;
    logic       isload;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
  } ctrl_t;

  // Bubble bundle: no side effects, ALU left on ADD.
  localparam ctrl_t CTRL_NOP = '{
    lui_sel:  1'b0,
    rd_wren:  1'b0,
    insn_vld: 1'b0,
    br_un:    1'b0,
    opa_sel:  1'b0,
    opb_sel:  1'b0,
    mem_wren: 1'b0,
    isload:   1'b0,
    wb_sel:   2'b00,
    alu_op:   ALU_ADD
  };

  // One in-flight destination tracker entry.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
  } slot_t;

  function automatic logic uses_rs1(input logic [4:0] opcode);
    return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [4:0] opcode);
    return (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
  endfunction

  function automatic logic slot_hit(input slot_t slot,
                                    input logic use1, input logic [4:0] rs1,
                                    input logic use2, input logic [4:0] rs2);
    return slot.wr && ((use1 && (slot.rd == rs1)) || (use2 && (slot.rd == rs2)));
  endfunction

endpackage

// File: rtl/id_hazard_cmp.sv
// Combinational RAW compare of the ID sources against the EX/MEM/WB slots.
// HAZARD_WB_BYPASS_EN: when defined, the WB slot is excluded from the compare.
module id_hazard_cmp
  import pipe_pkg::*;
(
  input  logic [4:0] i_opcode,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_insn_vld,
  input  logic       i_flush,
  input  slot_t      i_slot_ex,
  input  slot_t      i_slot_mem,
  input  slot_t      i_slot_wb,
  output logic [2:0] o_match,
  output logic       o_stall
);

  // The register file writes in the first half-cycle when bypass is on,
  // so a WB-stage producer is already visible to the ID read.
`ifdef HAZARD_WB_BYPASS_EN
  localparam logic WB_CHECK = 1'b0;
`else
  localparam logic WB_CHECK = 1'b1;
`endif

  logic use1;
  logic use2;

  always_comb begin
    use1       = i_insn_vld && uses_rs1(i_opcode) && (i_rs1 != 5'd0);
    use2       = i_insn_vld && uses_rs2(i_opcode) && (i_rs2 != 5'd0);
    o_match[0] = slot_hit(i_slot_ex,  use1, i_rs1, use2, i_rs2);
    o_match[1] = slot_hit(i_slot_mem, use1, i_rs1, use2, i_rs2);
    o_match[2] = WB_CHECK && slot_hit(i_slot_wb, use1, i_rs1, use2, i_rs2);
    // A flushed ID instruction is discarded, so it never needs to wait.
    o_stall    = (|o_match) && !i_flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW interlock: tracks rd of EX/MEM/WB and
// stalls IF/ID while injecting bubbles. Option macro: HAZARD_WB_BYPASS_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_lui_sel,
  input  logic            i_rd_wren,
  input  logic            i_insn_vld,
  input  logic            i_br_un,
  input  logic            i_opa_sel,
  input  logic            i_opb_sel,
  input  logic            i_mem_wren,
  input  logic            i_isload,
  input  logic [1:0]      i_wb_sel,
  input  logic [3:0]      i_alu_op,
  input  logic            i_flush,
  output logic            o_stall,
  output logic [31:0]     o_ex_instr,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [XLEN-1:0] o_ex_rs1_data,
  output logic [XLEN-1:0] o_ex_rs2_data,
  output logic [XLEN-1:0] o_ex_imm,
  output logic            o_ex_lui_sel,
  output logic            o_ex_rd_wren,
  output logic            o_ex_insn_vld,
  output logic            o_ex_br_un,
  output logic            o_ex_opa_sel,
  output logic            o_ex_opb_sel,
  output logic            o_ex_mem_wren,
  output logic            o_ex_isload,
  output logic [1:0]      o_ex_wb_sel,
  output logic [3:0]      o_ex_alu_op,
  output logic [4:0]      o_ex_rd
);

  // Handshake: o_stall=1 means ID is not accepted this cycle; upstream must
  // hold PC and IF/ID, and EX receives a bubble. i_flush discards ID instead.

  ctrl_t       id_ctrl;
  ctrl_t       ex_ctrl;
  slot_t       slot_ex;
  slot_t       slot_mem;
  slot_t       slot_wb;
  slot_t       slot_new;
  logic [2:0]  slot_match;
  logic        bubble;
  logic [4:0]  id_rd;

  assign id_rd = i_instr[11:7];

  always_comb begin
    id_ctrl          = CTRL_NOP;
    id_ctrl.lui_sel  = i_lui_sel;
    id_ctrl.rd_wren  = i_rd_wren;
    id_ctrl.insn_vld = i_insn_vld;
    id_ctrl.br_un    = i_br_un;
    id_ctrl.opa_sel  = i_opa_sel;
    id_ctrl.opb_sel  = i_opb_sel;
    id_ctrl.mem_wren = i_mem_wren;
    id_ctrl.isload   = i_isload;
    id_ctrl.wb_sel   = i_wb_sel;
    id_ctrl.alu_op   = i_alu_op;
  end

  id_hazard_cmp u_hazard (
    .i_opcode   (i_instr[6:2]),
    .i_rs1      (i_instr[19:15]),
    .i_rs2      (i_instr[24:20]),
    .i_insn_vld (i_insn_vld),
    .i_flush    (i_flush),
    .i_slot_ex  (slot_ex),
    .i_slot_mem (slot_mem),
    .i_slot_wb  (slot_wb),
    .o_match    (slot_match),
    .o_stall    (o_stall)
  );

  assign bubble = o_stall || i_flush;

  // Only a real, accepted writer of a non-zero register occupies a slot.
  always_comb begin
    slot_new.rd = id_rd;
    slot_new.wr = i_rd_wren && i_insn_vld && (id_rd != 5'd0) && !bubble;
  end

  // Slots shift every cycle, even while stalled, so a stall always drains.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slot_ex  <= '0;
      slot_mem <= '0;
      slot_wb  <= '0;
    end else begin
      slot_wb  <= slot_mem;
      slot_mem <= slot_ex;
      slot_ex  <= slot_new;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_ctrl       <= '0;
      o_ex_instr    <= '0;
      o_ex_pc       <= '0;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_imm      <= '0;
      o_ex_rd       <= '0;
    end else if (bubble) begin
      ex_ctrl       <= CTRL_NOP;
      o_ex_instr    <= '0;
      o_ex_pc       <= '0;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_imm      <= '0;
      o_ex_rd       <= '0;
    end else begin
      ex_ctrl       <= id_ctrl;
      o_ex_instr    <= i_instr;
      o_ex_pc       <= i_pc;
      o_ex_rs1_data <= i_rs1_data;
      o_ex_rs2_data <= i_rs2_data;
      o_ex_imm      <= i_imm;
      o_ex_rd       <= id_rd;
    end
  end

  assign o_ex_lui_sel  = ex_ctrl.lui_sel;
  assign o_ex_rd_wren  = ex_ctrl.rd_wren;
  assign o_ex_insn_vld = ex_ctrl.insn_vld;
  assign o_ex_br_un    = ex_ctrl.br_un;
  assign o_ex_opa_sel  = ex_ctrl.opa_sel;
  assign o_ex_opb_sel  = ex_ctrl.opb_sel;
  assign o_ex_mem_wren = ex_ctrl.mem_wren;
  assign o_ex_isload   = ex_ctrl.isload;
  assign o_ex_wb_sel   = ex_ctrl.wb_sel;
  assign o_ex_alu_op   = ex_ctrl.alu_op;

endmodule
